// File: rtl/output_scaler_pkg.sv
// Shared types, widths and the saturation-limit helper for the output scaler.
package output_scaler_pkg;

  localparam int FIXED_POINT_BITS  = 16;
  localparam int SHIFT_BITS        = 5;
  localparam int OUTPUT_WIDTH      = 8;
  localparam int BIAS_WIDTH        = 32;
  // |biased| of a 32-bit two's complement value always fits 32 unsigned bits.
  localparam int MAG_WIDTH         = BIAS_WIDTH;
  localparam int PROD_WIDTH        = MAG_WIDTH + FIXED_POINT_BITS;
  // Largest total shift is FIXED_POINT_BITS + 2^SHIFT_BITS - 1 = 47.
  localparam int TOTAL_SHIFT_WIDTH = 6;
  // Shifted magnitude is at most 33 bits; add room for sign and offset carry.
  localparam int SAT_WIDTH         = PROD_WIDTH - FIXED_POINT_BITS + 4;

  typedef struct packed {
    logic [FIXED_POINT_BITS-1:0] scale;
    logic [SHIFT_BITS-1:0]       shift;
    logic [BIAS_WIDTH-1:0]       bias;
    logic [OUTPUT_WIDTH-1:0]     offset;
  } param_t;

  typedef struct packed {
    logic signed [SAT_WIDTH-1:0] hi;
    logic signed [SAT_WIDTH-1:0] lo;
  } sat_limits_t;

  // Clamp range for the selected lane width; out-of-range widths fall back to max_bits.
  function automatic sat_limits_t sat_limits(input logic is_unsigned,
                                             input logic [3:0] bits,
                                             input int max_bits);
    int b;
    logic signed [SAT_WIDTH-1:0] one;
    sat_limits_t lim;
    b = int'(bits);
    if (b < 2 || b > max_bits) b = max_bits;
    one = SAT_WIDTH'(1);
    if (is_unsigned) begin
      lim.hi = (one <<< b) - one;
      lim.lo = '0;
    end else begin
      lim.hi = (one <<< (b - 1)) - one;
      lim.lo = -(one <<< (b - 1));
    end
    return lim;
  endfunction

endpackage

// File: rtl/output_scaler_param_rf.sv
// Per-channel parameter storage: flop array, one write port, one combinational read port.
module output_scaler_param_rf
  import output_scaler_pkg::*;
#(
  parameter int Depth     = 32,
  parameter int AddrWidth = $clog2(Depth)
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  param_t               wdata,
  input  logic [AddrWidth-1:0] raddr,
  output param_t               rdata
);

  param_t entries [Depth];

  // Entries clear to zero on reset; a write updates one entry.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < Depth; i++) entries[i] <= '0;
    end else if (we) begin
      entries[waddr] <= wdata;
    end
  end

  // Depth is a power of two, so every address selects a real entry.
  assign rdata = entries[raddr];

endmodule

// File: rtl/output_scaler_mc.sv
// Multi-channel output scaler: bias, fixed-point scale, round/shift, offset and
// saturate, in a 3-stage valid/ready pipeline with per-channel parameters.
//
// Handshake: a beat moves across an interface on a cycle where valid && ready.
// A producer holds valid and its payload stable until accepted; ready may
// depend combinationally on downstream ready. Each stage loads when it is
// empty or its contents are leaving this cycle.
module output_scaler_mc
  import output_scaler_pkg::*;
#(
  parameter int NumChannels    = 32,
  parameter int InputWidth     = 20,
  parameter int MaxOutputWidth = 8,
  parameter int FixedPointBits = 16,
  parameter int ShiftBits      = 5,
  localparam int ChWidth       = $clog2(NumChannels)
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          cfg_we,
  input  logic [ChWidth-1:0]            cfg_addr,
  input  logic [FixedPointBits-1:0]     cfg_scale,
  input  logic [ShiftBits-1:0]          cfg_shift,
  input  logic signed [31:0]            cfg_bias,
  input  logic [MaxOutputWidth-1:0]     cfg_offset,
  input  logic                          cfg_unsigned,
  input  logic [3:0]                    cfg_output_bits,
  input  logic                          cfg_round_en,
  input  logic [ChWidth:0]              cfg_num_channels,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [InputWidth-1:0]  in_data,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MaxOutputWidth-1:0]     out_data,
  output logic [ChWidth-1:0]            out_channel,
  output logic                          out_last,
  output logic                          busy,
  output logic                          cfg_err
);

  // Stage state
  logic                         s1_valid, s2_valid;
  logic                         s1_ready, s2_ready, s3_ready;
  logic [BIAS_WIDTH-1:0]        s1_biased;
  logic [FIXED_POINT_BITS-1:0]  s1_scale;
  logic [SHIFT_BITS-1:0]        s1_shift, s2_shift;
  logic [OUTPUT_WIDTH-1:0]      s1_offset, s2_offset;
  logic [ChWidth-1:0]           s1_ch, s2_ch;
  logic                         s1_last, s2_last;
  logic                         s2_neg;
  logic [PROD_WIDTH-1:0]        s2_prod;

  logic                         accept;
  logic [ChWidth-1:0]           ch_cnt;
  logic                         ch_wrap;
  logic                         cfg_ok;
  param_t                       cfg_entry;
  param_t                       rd_entry;
  logic [BIAS_WIDTH-1:0]        in_ext;
  logic [MAG_WIDTH-1:0]         s1_mag;

  assign s3_ready = !out_valid || out_ready;
  assign s2_ready = !s2_valid || s3_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign in_ready = nrst && s1_ready;
  assign busy     = s1_valid || s2_valid || out_valid;
  assign accept   = in_valid && in_ready;

  // Writes only land when the datapath is idle and no beat is being offered.
  assign cfg_ok = cfg_we && !busy && !in_valid;

  assign cfg_entry.scale  = cfg_scale;
  assign cfg_entry.shift  = cfg_shift;
  assign cfg_entry.bias   = cfg_bias;
  assign cfg_entry.offset = cfg_offset;

  output_scaler_param_rf #(.Depth(NumChannels)) u_param_rf (
    .clk   (clk),
    .nrst  (nrst),
    .we    (cfg_ok),
    .waddr (cfg_addr),
    .wdata (cfg_entry),
    .raddr (ch_cnt),
    .rdata (rd_entry)
  );

  // Counter wraps after the last active channel or after an in_last beat.
  assign ch_wrap = in_last ||
                   (({1'b0, ch_cnt} + (ChWidth+1)'(1)) == cfg_num_channels);

  // Channel counter and rejected-write pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ch_cnt  <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      if (accept) ch_cnt <= ch_wrap ? '0 : ch_cnt + ChWidth'(1);
    end
  end

  assign in_ext = {{(BIAS_WIDTH-InputWidth){in_data[InputWidth-1]}}, in_data};

  // S1: add bias and capture the beat's channel parameters.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_valid  <= 1'b0;
      s1_biased <= '0;
      s1_scale  <= '0;
      s1_shift  <= '0;
      s1_offset <= '0;
      s1_ch     <= '0;
      s1_last   <= 1'b0;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_biased <= in_ext + rd_entry.bias;
        s1_scale  <= rd_entry.scale;
        s1_shift  <= rd_entry.shift;
        s1_offset <= rd_entry.offset;
        s1_ch     <= ch_cnt;
        s1_last   <= in_last;
      end
    end
  end

  assign s1_mag = s1_biased[BIAS_WIDTH-1] ? (~s1_biased + MAG_WIDTH'(1)) : s1_biased;

  // S2: scale the magnitude, keep the sign for later.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s2_valid  <= 1'b0;
      s2_prod   <= '0;
      s2_neg    <= 1'b0;
      s2_shift  <= '0;
      s2_offset <= '0;
      s2_ch     <= '0;
      s2_last   <= 1'b0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_prod   <= PROD_WIDTH'(s1_mag) * PROD_WIDTH'(s1_scale);
        s2_neg    <= s1_biased[BIAS_WIDTH-1];
        s2_shift  <= s1_shift;
        s2_offset <= s1_offset;
        s2_ch     <= s1_ch;
        s2_last   <= s1_last;
      end
    end
  end

  logic [TOTAL_SHIFT_WIDTH-1:0] total_shift;
  logic [PROD_WIDTH:0]          round_add, rounded, shifted;
  logic signed [SAT_WIDTH-1:0]  mag_q, signed_q, offset_q, sum_q, sat_q;
  logic signed [SAT_WIDTH-1:0]  sat_hi, sat_lo;
  sat_limits_t                  lim;

  // S3 math: round on the magnitude, reapply sign, add offset, clamp.
  always_comb begin
    total_shift = TOTAL_SHIFT_WIDTH'(FIXED_POINT_BITS) + TOTAL_SHIFT_WIDTH'(s2_shift);
    round_add   = '0;
    if (cfg_round_en) round_add = (PROD_WIDTH+1)'(1) << (total_shift - TOTAL_SHIFT_WIDTH'(1));
    rounded  = {1'b0, s2_prod} + round_add;
    shifted  = rounded >> total_shift;
    mag_q    = SAT_WIDTH'(shifted);
    signed_q = s2_neg ? -mag_q : mag_q;
    offset_q = SAT_WIDTH'(s2_offset);
    sum_q    = signed_q + offset_q;
    lim      = sat_limits(cfg_unsigned, cfg_output_bits, MaxOutputWidth);
    sat_hi   = lim.hi;
    sat_lo   = lim.lo;
    if (sum_q > sat_hi)      sat_q = sat_hi;
    else if (sum_q < sat_lo) sat_q = sat_lo;
    else                     sat_q = sum_q;
  end

  // S3 register: the clamped value is in range, so its low bits are already
  // zero-padded (unsigned) or sign-extended (signed) above the lane width.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_channel <= '0;
      out_last    <= 1'b0;
    end else if (s3_ready) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data    <= MaxOutputWidth'(sat_q);
        out_channel <= s2_ch;
        out_last    <= s2_last;
      end
    end
  end

endmodule

// File: tb/tb_output_scaler_mc.sv
// Directed bench for output_scaler_mc with an expected-beat queue.
module tb_output_scaler_mc;

  localparam int EW = 14; // {last, channel[4:0], data[7:0]}

  logic               clk;
  logic               nrst;
  logic               cfg_we;
  logic [4:0]         cfg_addr;
  logic [15:0]        cfg_scale;
  logic [4:0]         cfg_shift;
  logic signed [31:0] cfg_bias;
  logic [7:0]         cfg_offset;
  logic               cfg_unsigned;
  logic [3:0]         cfg_output_bits;
  logic               cfg_round_en;
  logic [5:0]         cfg_num_channels;
  logic               in_valid;
  logic               in_ready;
  logic signed [19:0] in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         out_data;
  logic [4:0]         out_channel;
  logic               out_last;
  logic               busy;
  logic               cfg_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];

  output_scaler_mc dut (
    .clk(clk), .nrst(nrst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_scale(cfg_scale), .cfg_shift(cfg_shift), .cfg_bias(cfg_bias),
    .cfg_offset(cfg_offset), .cfg_unsigned(cfg_unsigned),
    .cfg_output_bits(cfg_output_bits), .cfg_round_en(cfg_round_en),
    .cfg_num_channels(cfg_num_channels), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_channel(out_channel), .out_last(out_last), .busy(busy),
    .cfg_err(cfg_err)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_beat(input int ch, input int val, input logic last);
    exp_q.push_back({last, 5'(ch), 8'(val)});
  endtask

  task automatic send(input int d, input logic last);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = 20'(d);
    in_last  = last;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("send_accept", 32'(guard < 100), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic cfg_write(input int addr, input int scale, input int shift,
                           input int bias, input int offset);
    cfg_we     = 1'b1;
    cfg_addr   = 5'(addr);
    cfg_scale  = 16'(scale);
    cfg_shift  = 5'(shift);
    cfg_bias   = bias;
    cfg_offset = 8'(offset);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check(tag, 32'(guard < 60), 1);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every transferred beat must match the head of exp_q.
  always @(negedge clk) begin
    logic [EW-1:0] got;
    logic [EW-1:0] want;
    if (nrst && out_valid && out_ready) begin
      got = {out_last, out_channel, out_data};
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_errors++;
        $error("FAIL unexpected_beat: observed=%0h expected=none", got);
      end
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        n_checks++;
        assert (got === want) else begin
          n_errors++;
          $error("FAIL beat: observed=%0h expected=%0h", got, want);
        end
      end
    end
  end

  int ch_val[3]  = '{63, 32, 16};
  int pass_b_ch[7] = '{0, 1, 2, 0, 1, 0, 1};

  initial begin
    nrst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_scale = '0; cfg_shift = '0;
    cfg_bias = '0; cfg_offset = '0; cfg_unsigned = 1'b0; cfg_output_bits = 4'd8;
    cfg_round_en = 1'b0; cfg_num_channels = 6'd1; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cfg_err", 32'(cfg_err), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_channel", 32'(out_channel), 0);
    check("rst_out_last", 32'(out_last), 0);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;

    // Parameters start at zero
    expect_beat(0, 0, 1'b0);
    send(77, 1'b0);
    wait_idle("drain_zero_param");

    // Half scale, signed 8-bit, with latency check
    cfg_write(0, 'h8000, 0, 0, 0);
    @(negedge clk);
    check("cfg_ok_no_err", 32'(cfg_err), 0);
    @(posedge clk); #1;
    expect_beat(0, 50, 1'b0);
    send(100, 1'b0);
    @(negedge clk); check("lat_cycle1", 32'(out_valid), 0);
    @(negedge clk); check("lat_cycle2", 32'(out_valid), 0);
    @(negedge clk); check("lat_cycle3", 32'(out_valid), 1);
    @(posedge clk); #1;
    expect_beat(0, -50, 1'b0);
    send(-100, 1'b0);
    wait_idle("drain_half");

    // Truncate vs round half away from zero
    expect_beat(0, 1, 1'b0);  send(3, 1'b0);
    expect_beat(0, -1, 1'b0); send(-3, 1'b0);
    wait_idle("drain_trunc");
    cfg_round_en = 1'b1;
    expect_beat(0, 2, 1'b0);  send(3, 1'b0);
    expect_beat(0, -2, 1'b0); send(-3, 1'b0);
    wait_idle("drain_round");
    cfg_round_en = 1'b0;

    // Saturation in signed and unsigned modes
    cfg_write(0, 'hFFFF, 0, 0, 0);
    expect_beat(0, 127, 1'b0);  send(1000, 1'b0);
    expect_beat(0, -128, 1'b0); send(-1000, 1'b0);
    wait_idle("drain_sat_s8");
    cfg_unsigned = 1'b1; cfg_output_bits = 4'd4;
    expect_beat(0, 0, 1'b0);  send(-5, 1'b0);
    expect_beat(0, 15, 1'b0); send(40, 1'b0);
    wait_idle("drain_sat_u4");
    cfg_output_bits = 4'd9;  // out of range -> full 8-bit lane
    expect_beat(0, 255, 1'b0); send(1000, 1'b0);
    wait_idle("drain_sat_u9");
    cfg_output_bits = 4'd0;
    expect_beat(0, 39, 1'b0); send(40, 1'b0);
    wait_idle("drain_sat_u0");
    cfg_unsigned = 1'b0; cfg_output_bits = 4'd4;
    expect_beat(0, 7, 1'b0);  send(1000, 1'b0);
    expect_beat(0, -8, 1'b0); send(-1000, 1'b0);
    wait_idle("drain_sat_s4");
    cfg_output_bits = 4'd8;

    // Bias, post-shift and offset: (50-10)*0.5>>1+3=13; (-100-10)*0.5>>1 -> -27+3=-24
    cfg_write(0, 'h8000, 1, -10, 3);
    expect_beat(0, 13, 1'b0);  send(50, 1'b0);
    expect_beat(0, -24, 1'b0); send(-100, 1'b0);
    wait_idle("drain_bias_off");

    // Three channels, back-to-back
    cfg_write(0, 'hFFFF, 0, 0, 0);
    cfg_write(1, 'h8000, 0, 0, 0);
    cfg_write(2, 'h4000, 0, 0, 0);
    cfg_num_channels = 6'd3;
    for (int i = 0; i < 7; i++) begin
      expect_beat(i % 3, ch_val[i % 3], i == 6);
      send(64, i == 6);
    end
    @(negedge clk); @(negedge clk); #1;
    check("flow_one_left", exp_q.size(), 1);
    @(negedge clk); #1;
    check("flow_none_left", exp_q.size(), 0);
    wait_idle("drain_pass_a");

    // in_last on the fifth beat restarts the channel sequence
    for (int i = 0; i < 7; i++) begin
      expect_beat(pass_b_ch[i], ch_val[pass_b_ch[i]], i == 4 || i == 6);
      send(64, i == 4 || i == 6);
    end
    wait_idle("drain_pass_b");

    // Backpressure: out_ready low for 5 cycles during 8 beats
    for (int i = 0; i < 8; i++) begin
      int d;
      d = 16 * (i + 1);
      case (i % 3)
        0: expect_beat(0, d - 1, i == 7);
        1: expect_beat(1, d / 2, i == 7);
        default: expect_beat(2, d / 4, i == 7);
      endcase
    end
    fork
      begin
        for (int i = 0; i < 8; i++) send(16 * (i + 1), i == 7);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("hold_valid", 32'(out_valid), 1);
          check("hold_beat", 32'({out_last, out_channel, out_data}), 32'(exp_q[0]));
          check("hold_in_ready", 32'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_idle("drain_backpressure");

    // Write while busy is rejected and leaves the entry alone
    expect_beat(0, 63, 1'b0);
    send(64, 1'b0);
    check("busy_during_write", 32'(busy), 1);
    cfg_write(1, 'h1234, 0, 0, 0);
    @(negedge clk); check("cfg_err_pulse", 32'(cfg_err), 1);
    @(negedge clk); check("cfg_err_clear", 32'(cfg_err), 0);
    wait_idle("drain_cfg_err");
    expect_beat(1, 32, 1'b1);
    send(64, 1'b1);
    wait_idle("drain_ch1_kept");

    // Reset mid-stream: two beats in flight with out_ready low
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 20'sd64; in_last = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_busy", 32'(busy), 1);
    nrst = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_in_ready", 32'(in_ready), 0);
    check("mid_rst_out_data", 32'(out_data), 0);
    check("mid_rst_out_channel", 32'(out_channel), 0);
    check("mid_rst_out_last", 32'(out_last), 0);
    check("mid_rst_cfg_err", 32'(cfg_err), 0);
    @(posedge clk); #1;
    nrst = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_rst_quiet", 32'(out_valid), 0);
    end
    @(posedge clk); #1;
    // Counter back at ch0 and parameters cleared -> zero output
    expect_beat(0, 0, 1'b1);
    send(64, 1'b1);
    wait_idle("drain_post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/output_scaler_mc.md
OUTPUT_SCALER_MC -- requirements
Module: output_scaler_mc

Interface
REQ-001 SHALL have parameter NumChannels, default 32, meaning the per-channel parameter entries (power of 2).
REQ-002 SHALL have parameter InputWidth, default 20, meaning the signed accumulator input width.
REQ-003 SHALL have parameter MaxOutputWidth, default 8, meaning the output lane width.
REQ-004 SHALL have parameter FixedPointBits, default 16, meaning the scale fraction bits.
REQ-005 SHALL have parameter ShiftBits, default 5, meaning the post-shift field width.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port nrst, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have config write ports: cfg_we (input, 1), cfg_addr (input, log2(NumChannels)), cfg_scale (input, FixedPointBits, unsigned), cfg_shift (input, ShiftBits), cfg_bias (input, 32, signed), cfg_offset (input, MaxOutputWidth).
REQ-009 SHALL have global mode ports: cfg_unsigned (input, 1), cfg_output_bits (input, 4), cfg_round_en (input, 1), cfg_num_channels (input, log2(NumChannels)+1).
REQ-010 SHALL have input stream ports: in_valid (input, 1), in_ready (output, 1), in_data (input, InputWidth, signed), in_last (input, 1).
REQ-011 SHALL have output stream ports: out_valid (output, 1), out_ready (input, 1), out_data (output, MaxOutputWidth), out_channel (output, log2(NumChannels)), out_last (output, 1).
REQ-012 SHALL have status ports: busy (output, 1), meaning any stage is valid; cfg_err (output, 1), meaning a one-cycle pulse on a rejected write.

Function
REQ-013 A beat SHALL transfer on valid&&ready; data and channel SHALL hold while valid&&!ready.
REQ-014 The channel counter SHALL start at 0, increment per accepted input beat, wrap to 0 after cfg_num_channels-1, and return to 0 after a beat with in_last=1.
REQ-015 The 3-stage pipeline SHALL be S1: sext(in_data)+bias (32b), parameter capture; S2: |biased|*scale (48b magnitude), sign kept; S3: round/shift, offset, saturate.
REQ-016 Latency SHALL be 3 cycles, with 1 beat/cycle throughput while out_ready=1.
REQ-017 Each stage SHALL advance when the next stage is empty or advancing; in_ready = !S1valid || S1 advancing; there SHALL be no bubbles under continuous flow.
REQ-018 With total shift T=FixedPointBits+shift: when round_en=0, mag>>T (truncate toward zero); when round_en=1, (mag+2^(T-1))>>T (half away from zero); the sign SHALL then be reapplied.
REQ-019 The shifted value plus zero-extended offset SHALL saturate to [0, 2^b-1] (unsigned) or [-2^(b-1), 2^(b-1)-1] (signed), b=cfg_output_bits; b outside 2..MaxOutputWidth SHALL be treated as MaxOutputWidth.
REQ-020 out_data bits above b SHALL be zero (unsigned) or sign-extended (signed).
REQ-021 Parameters SHALL be read by S1 using the beat's channel; out_channel and out_last SHALL travel with the beat.
REQ-022 cfg_we SHALL write when busy=0 and in_valid=0; otherwise the write SHALL be ignored and cfg_err pulsed.
REQ-023 Global mode inputs SHALL be static while busy=1.

Reset
REQ-024 nrst low SHALL clear all stage valids, the channel counter and cfg_err, and zero every parameter entry.
REQ-025 out_valid, out_data, out_channel, out_last, busy and in_ready SHALL be 0 during reset.
REQ-026 Reset mid-stream SHALL drop in-flight beats, with nothing emitted after release.

Structure
REQ-027 output_scaler_pkg SHALL hold the per-channel parameter struct typedef, the product/total-shift width constants and the saturation-limit function.
REQ-028 The parameter storage SHALL be sub-module output_scaler_param_rf (flop array, 1 write port, 1 combinational read port).

Verification
REQ-029 ch0 scale=0x8000, shift=0, bias=0, signed, b=8; inputs 100, -100 -> 50, -50 after 3 cycles.
REQ-030 in=3 and -3, scale=0x8000: round_en=0 -> 1, -1; round_en=1 -> 2, -2.
REQ-031 scale=0xFFFF, in=1000 -> 127; in=-1000 -> -128; unsigned b=4, in=-5 -> 0, in=40 -> 15.
REQ-032 num_channels=3, scales 0x10000-1/0x8000/0x4000, 7 beats of 64 -> channels 0,1,2,0,1,2,0 with values 63,32,16; in_last on beat 5 -> beat 6 on ch0.
REQ-033 out_ready held low for 5 cycles during a stream of 8 beats -> in_ready drops after 3 held beats, outputs stable, no loss or duplication, order preserved.
REQ-034 cfg_we while busy -> cfg_err pulses and the entry is unchanged; nrst asserted mid-stream -> all outputs 0 and no stale beats afterwards.
